// File: rtl/note_sequencer.sv
// Fret/string note recorder and player: samples contacts once per beat, stores one-hot
// string x fret notes in a small memory and replays them, optionally looping.
module note_sequencer #(
    parameter int unsigned NUM_STRINGS = 6,
    parameter int unsigned NUM_FRETS   = 4,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned DIV_W       = 27,
    parameter int unsigned GUARD       = 10000,
    localparam int unsigned NOTE_W     = NUM_STRINGS * (NUM_FRETS + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DIV_W-1:0]       beat_period,
    input  logic                   cmd_record,
    input  logic                   cmd_play,
    input  logic                   cmd_stop,
    input  logic                   loop_en,
    input  logic [NUM_STRINGS-1:0] strings,
    input  logic [NUM_FRETS-1:0]   frets,
    output logic [1:0]             state,
    output logic [NOTE_W-1:0]      note_out,
    output logic                   note_valid,
    output logic                   beat,
    output logic [ADDR_W-1:0]      address,
    output logic [ADDR_W:0]        length,
    output logic                   full
);

    localparam int unsigned FRET_W = $clog2(NUM_FRETS + 1);
    localparam logic [DIV_W-1:0] MinPeriod = DIV_W'(GUARD + 2);
    localparam logic [DIV_W-1:0] GuardCnt = DIV_W'(GUARD);
    localparam logic [ADDR_W:0] LastLen = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRecord = 2'd1,
        StPlay   = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [DIV_W-1:0]       timer_q, timer_d;
    logic [ADDR_W-1:0]      address_q, address_d;
    logic [ADDR_W:0]        length_q, length_d;
    logic                   full_q, full_d;
    logic [NUM_STRINGS-1:0] sacc_q, sacc_d;
    logic [FRET_W-1:0]      facc_q, facc_d;
    logic [NOTE_W-1:0]      note_out_q, note_out_d;
    logic                   note_valid_q, note_valid_d;

    logic [NOTE_W-1:0]      mem_q [DEPTH];
    logic                   wr_en;
    logic [NOTE_W-1:0]      note_enc;
    logic [DIV_W-1:0]       reload;
    logic [FRET_W-1:0]      bar_hi;
    logic                   beat_w;

    always_comb begin
        reload = ((beat_period < MinPeriod) ? MinPeriod : beat_period) - 1'b1;
        beat_w = (state_q != StIdle) && (timer_q == '0);
        note_enc = NOTE_W'(sacc_q) << (32'(facc_q) * NUM_STRINGS);

        bar_hi = '0;
        for (int i = 0; i < NUM_FRETS; i++) begin
            if (frets[i]) bar_hi = FRET_W'(i + 1);
        end

        state_d      = state_q;
        timer_d      = timer_q;
        address_d    = address_q;
        length_d     = length_q;
        full_d       = full_q;
        sacc_d       = sacc_q;
        facc_d       = facc_q;
        note_out_d   = note_out_q;
        note_valid_d = 1'b0;
        wr_en        = 1'b0;

        unique case (state_q)
            StIdle: begin
                // The final played/recorded note is shown for one cycle before clearing.
                note_out_d = '0;
                if (cmd_stop) begin
                    state_d = StIdle;
                end else if (cmd_record) begin
                    state_d   = StRecord;
                    timer_d   = reload;
                    address_d = '0;
                    length_d  = '0;
                    full_d    = 1'b0;
                    sacc_d    = '0;
                    facc_d    = '0;
                end else if (cmd_play && (length_q != '0)) begin
                    state_d   = StPlay;
                    timer_d   = reload;
                    address_d = '0;
                end
            end
            StRecord: begin
                timer_d = beat_w ? reload : timer_q - 1'b1;
                if (cmd_stop) begin
                    state_d    = StIdle;
                    note_out_d = '0;
                end else if (beat_w) begin
                    wr_en        = 1'b1;
                    note_out_d   = note_enc;
                    note_valid_d = 1'b1;
                    address_d    = address_q + 1'b1;
                    length_d     = length_q + 1'b1;
                    sacc_d       = '0;
                    facc_d       = '0;
                    if (length_q == LastLen) begin
                        full_d  = 1'b1;
                        state_d = StIdle;
                    end
                end else if (timer_q >= GuardCnt) begin
                    sacc_d = sacc_q | strings;
                    facc_d = (bar_hi > facc_q) ? bar_hi : facc_q;
                end
            end
            StPlay: begin
                timer_d = beat_w ? reload : timer_q - 1'b1;
                if (cmd_stop) begin
                    state_d    = StIdle;
                    note_out_d = '0;
                end else if (beat_w) begin
                    // note_out_q doubles as the memory's read register.
                    note_out_d   = mem_q[address_q];
                    note_valid_d = 1'b1;
                    if ({1'b0, address_q} == length_q - 1'b1) begin
                        address_d = '0;
                        if (!loop_en) state_d = StIdle;
                    end else begin
                        address_d = address_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d    = StIdle;
                note_out_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            address_q    <= '0;
            length_q     <= '0;
            full_q       <= 1'b0;
            sacc_q       <= '0;
            facc_q       <= '0;
            note_out_q   <= '0;
            note_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            address_q    <= address_d;
            length_q     <= length_d;
            full_q       <= full_d;
            sacc_q       <= sacc_d;
            facc_q       <= facc_d;
            note_out_q   <= note_out_d;
            note_valid_q <= note_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[address_q] <= note_enc;
    end

    assign state      = state_q;
    assign note_out   = note_out_q;
    assign note_valid = note_valid_q;
    assign beat       = beat_w;
    assign address    = address_q;
    assign length     = length_q;
    assign full       = full_q;

endmodule
